// File: rtl/uart_rx_deserializer.sv
// 16x-oversampled UART receiver: 2-flop synchronizer, 3-sample majority vote,
// optional parity and one/two stop bits, break detection, one-clk valid pulse.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxBit_i,
  input  logic       SampleTick_i,
  input  logic       Enable_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  input  logic       TwoStop_i,
  output logic [7:0] Data_o,
  output logic       DataValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o,
  output logic       BreakDet_o,
  output logic       Busy_o
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q, rx;
  logic [3:0] tick_q, tick_d, cnt;
  logic [2:0] bit_q, bit_d;
  logic       s7_q, s7_d, s8_q, s8_d, bitval_q, bitval_d, vote;
  logic [7:0] shift_q, shift_d;
  logic       par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
  logic       par_bit_q, par_bit_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic       busy_q, busy_d;
  logic       done, first_stop;

  assign rx = sync2_q;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    bitval_d   = bitval_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    done       = 1'b0;
    first_stop = 1'b1;
    // tick_q holds the count of the last tick seen; cnt is this tick's count
    cnt        = tick_q + 4'd1;
    vote       = (s7_q & s8_q) | (s7_q & rx) | (s8_q & rx);

    if (SampleTick_i && state_q != IDLE) begin
      tick_d = cnt;
      if (cnt == 4'd7) s7_d = rx;
      if (cnt == 4'd8) s8_d = rx;
      if (cnt == 4'd9) bitval_d = vote;
    end

    case (state_q)
      IDLE: if (SampleTick_i && Enable_i && !rx) begin
        state_d    = START;
        tick_d     = '0;
        bit_d      = '0;
        par_en_d   = ParityEn_i;
        par_odd_d  = ParityOdd_i;
        two_stop_d = TwoStop_i;
      end
      START: if (SampleTick_i) begin
        if (cnt == 4'd9 && vote)       state_d = IDLE;
        else if (cnt == TICK_LAST) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: if (SampleTick_i && cnt == TICK_LAST) begin
        shift_d = {bitval_q, shift_q[7:1]};
        if (bit_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP1;
        else                   bit_d   = bit_q + 3'd1;
      end
      PARITY: if (SampleTick_i && cnt == TICK_LAST) begin
        par_bit_d = bitval_q;
        state_d   = STOP1;
      end
      STOP1: if (SampleTick_i) begin
        if (cnt == 4'd9 && !two_stop_q)              done    = 1'b1;
        else if (cnt == TICK_LAST && two_stop_q)     state_d = STOP2;
      end
      STOP2: if (SampleTick_i && cnt == 4'd9) done = 1'b1;
      BREAK_WAIT: if (SampleTick_i && rx) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // With two stop bits, bitval_q still carries the first stop bit's vote here
    if (!Enable_i) begin
      state_d = IDLE;
    end else if (done) begin
      first_stop = two_stop_q ? bitval_q : vote;
      data_d     = shift_q;
      valid_d    = 1'b1;
      ferr_d     = !vote || !first_stop;
      perr_d     = par_en_q & (^shift_q ^ par_bit_q ^ par_odd_q);
      brk_d      = (shift_q == 8'h00) && !(par_en_q && par_bit_q) && !first_stop;
      state_d    = brk_d ? BREAK_WAIT : IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      bitval_q   <= 1'b1;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= RxBit_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      bitval_q   <= bitval_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = valid_q;
  assign ParityErr_o = perr_q;
  assign FrameErr_o  = ferr_q;
  assign BreakDet_o  = brk_q;
  assign Busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven tick by tick and
// each completed character is checked against a queue of expected results.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst, RxBit_i, SampleTick_i, Enable_i, ParityEn_i, ParityOdd_i, TwoStop_i;
  logic [7:0] Data_o;
  logic       DataValid_o, ParityErr_o, FrameErr_o, BreakDet_o, Busy_o;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_rx_deserializer #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .RxBit_i(RxBit_i), .SampleTick_i(SampleTick_i),
    .Enable_i(Enable_i), .ParityEn_i(ParityEn_i), .ParityOdd_i(ParityOdd_i),
    .TwoStop_i(TwoStop_i), .Data_o(Data_o), .DataValid_o(DataValid_o),
    .ParityErr_o(ParityErr_o), .FrameErr_o(FrameErr_o), .BreakDet_o(BreakDet_o),
    .Busy_o(Busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sample tick: line set, then a one-clk SampleTick_i strobe 3 clks later
  task automatic one_tick(input logic v);
    RxBit_i = v;
    repeat (3) @(posedge clk);
    #1 SampleTick_i = 1'b1;
    @(posedge clk);
    #1 SampleTick_i = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    repeat (16) one_tick(v);
  endtask

  task automatic idle(input int n);
    repeat (n) one_tick(1'b1);
  endtask

  task automatic send_frame(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (DataValid_o === 1'b1) begin
      check("valid_expected", {7'd0, exp_q.size() != 0}, 8'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data",   Data_o,               e.data);
        check("perr",   {7'd0, ParityErr_o},  {7'd0, e.perr});
        check("ferr",   {7'd0, FrameErr_o},   {7'd0, e.ferr});
        check("brk",    {7'd0, BreakDet_o},   {7'd0, e.brk});
      end
    end
  end

  initial begin
    rst = 1'b1; RxBit_i = 1'b1; SampleTick_i = 1'b0; Enable_i = 1'b1;
    ParityEn_i = 1'b0; ParityOdd_i = 1'b0; TwoStop_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  Data_o,               8'h00);
    check("rst_valid", {7'd0, DataValid_o},  8'd0);
    check("rst_perr",  {7'd0, ParityErr_o},  8'd0);
    check("rst_ferr",  {7'd0, FrameErr_o},   8'd0);
    check("rst_brk",   {7'd0, BreakDet_o},   8'd0);
    check("rst_busy",  {7'd0, Busy_o},       8'd0);
    rst = 1'b0;
    idle(20);

    // 8N1 0xA5
    exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    send_frame({2'b00, 1'b1, 8'hA5, 1'b0}, 10);
    idle(20);
    check("t1_drain", 8'(exp_q.size()), 8'd0);
    check("t1_busy",  {7'd0, Busy_o},   8'd0);

    // false start: 4 low ticks then high
    repeat (4) one_tick(1'b0);
    check("t2_busy_hi", {7'd0, Busy_o}, 8'd1);
    repeat (6) one_tick(1'b1);
    check("t2_busy_lo", {7'd0, Busy_o}, 8'd0);
    idle(20);

    // 8E1 0x07: parity bit 0 is wrong, 1 is right
    ParityEn_i = 1'b1; ParityOdd_i = 1'b0;
    exp_q.push_back('{data: 8'h07, perr: 1'b1, ferr: 1'b0, brk: 1'b0});
    send_frame({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(20);
    exp_q.push_back('{data: 8'h07, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    send_frame({1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(20);
    check("t3_drain", 8'(exp_q.size()), 8'd0);

    // 8N2 0x3C with second stop bit low
    ParityEn_i = 1'b0; TwoStop_i = 1'b1;
    exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1, brk: 1'b0});
    send_frame({1'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    idle(32);
    check("t4_drain", 8'(exp_q.size()), 8'd0);
    TwoStop_i = 1'b0;

    // break: 30 bit times low, then 8N1 0x55
    exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    repeat (30) send_bit(1'b0);
    idle(32);
    send_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10);
    idle(20);
    check("t5_drain", 8'(exp_q.size()), 8'd0);

    // 0x81 with a one-tick high glitch at tick 8 of data bit 1
    exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (8) one_tick(1'b0);
    one_tick(1'b1);
    repeat (7) one_tick(1'b0);
    repeat (5) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(20);
    check("t6_drain", 8'(exp_q.size()), 8'd0);
    check("t6_data",  Data_o,           8'h81);

    // reset during bit 3 of the next frame
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    repeat (8) one_tick(1'b1);
    check("t6_busy_mid", {7'd0, Busy_o}, 8'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_data",  Data_o,              8'h00);
    check("t6_rst_valid", {7'd0, DataValid_o}, 8'd0);
    check("t6_rst_ferr",  {7'd0, FrameErr_o},  8'd0);
    check("t6_rst_busy",  {7'd0, Busy_o},      8'd0);
    rst = 1'b0;
    idle(40);
    check("t6_no_output", 8'(exp_q.size()), 8'd0);
    check("t6_data_hold", Data_o,           8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Bit-level UART receiver. It sits directly downstream of the UART mode-select stage and consumes that stage's RxModulePort_o serial line (idle high). It oversamples the line at 16x baud, majority-votes each bit, and checks parity and stop bits. Each received character is presented as a one-cycle-valid parallel byte with error flags to the Rx buffer/control logic.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; fixed at 16 (4-bit tick counter)
DATA_BITS, 8, data bits per character, LSB first

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous reset, active-high
RxBit_i  input  1  serial line from the mode-select stage; asynchronous to clk; idle high
SampleTick_i  input  1  one-clk strobe at 16x baud rate
Enable_i  input  1  receiver enable
ParityEn_i  input  1  1 = parity bit present after the data bits
ParityOdd_i  input  1  1 = odd parity, 0 = even parity
TwoStop_i  input  1  1 = two stop bits, 0 = one stop bit
Data_o  output  8  last received character
DataValid_o  output  1  one-clk pulse: Data_o and all error flags are valid
ParityErr_o  output  1  parity mismatch; qualified by DataValid_o
FrameErr_o  output  1  a stop bit sampled 0; qualified by DataValid_o
BreakDet_o  output  1  break character; qualified by DataValid_o
Busy_o  output  1  1 whenever state != IDLE

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state IDLE; Data_o = 0x00; DataValid_o, ParityErr_o, FrameErr_o, BreakDet_o, Busy_o = 0; both synchronizer flops = 1; tick and bit counters = 0.
- Reset asserted mid-frame aborts the frame with no output.
- Synchronizer: 2-flop synchronizer on RxBit_i (2-clk latency). All logic below uses the synchronized line.
- Tick rule: tick counter, bit counter and sampling advance only on cycles where SampleTick_i = 1. Otherwise all state holds.
- Sampling: within each bit, samples are taken at tick counts 7, 8 and 9. The bit value is the majority of the three, registered at tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE:
  - On a tick with Enable_i = 1 and the line at 0: go to START, tick counter = 0 (this tick is count 0).
  - ParityEn_i, ParityOdd_i and TwoStop_i are latched here; changes mid-frame are ignored.
- START:
  - Voted bit = 1 at tick 9: false start; return to IDLE immediately, no output.
  - Otherwise at tick 15: go to DATA, bit counter = 0.
- DATA:
  - At tick 15, shift the voted bit into the shift register MSB; the result is LSB-first.
  - After bit 7: go to PARITY if ParityEn is latched, else STOP1.
- PARITY:
  - ParityErr = XOR(data bits, parity bit) XOR ParityOdd_latched; 1 means error.
  - At tick 15: go to STOP1.
- STOP1:
  - With TwoStop latched: record the bit at tick 9; at tick 15 go to STOP2.
  - Otherwise: complete the frame at tick 9.
- STOP2: complete the frame at tick 9.
- Frame completion: the completing tick 9 is in the last stop state. On the clk after that tick:
  - Data_o is loaded.
  - DataValid_o pulses for exactly 1 clk.
  - FrameErr_o = 1 if any stop bit is 0.
  - ParityErr_o = computed value, or 0 if parity is disabled.
  - BreakDet_o = 1 if data = 0x00, parity bit (if present) = 0, and the first stop bit = 0.
  - Next state: BREAK_WAIT if BreakDet, else IDLE. Early return at mid-stop allows resynchronisation on back-to-back frames.
- Flag lifetime: flags are only meaningful while DataValid_o = 1. Data_o holds until the next completed frame.
- BREAK_WAIT: stay until a tick sees the line at 1, then go to IDLE. This prevents repeated false frames while the line is held low.
- Enable_i = 0 in any state: go to IDLE on the next clk, abort the frame, no DataValid_o.
- Busy_o: registered; 1 in every state other than IDLE, including BREAK_WAIT.

Test Plan:
1. 8N1 frame 0xA5, SampleTick_i every 4 clk -> exactly one DataValid_o pulse, Data_o = 0xA5, all error flags 0, Busy_o returns to 0.
2. Line low for 4 ticks then high -> no DataValid_o; Busy_o = 0 by the clk after tick 9 of START.
3. 8E1 frame 0x07 with parity bit 0 -> DataValid_o with Data_o = 0x07, ParityErr_o = 1. The same frame with parity bit 1 -> ParityErr_o = 0.
4. 8N2 frame 0x3C with second stop bit 0 -> Data_o = 0x3C, FrameErr_o = 1, BreakDet_o = 0.
5. Line held low for 30 bit times, then high, then 8N1 frame 0x55:
   - exactly one pulse with Data_o = 0x00, FrameErr_o = 1, BreakDet_o = 1;
   - then one pulse with Data_o = 0x55 and no errors.
6. Single-tick high glitch at tick 8 of a 0 data bit in frame 0x81 -> voted out, Data_o = 0x81. Then rst asserted during bit 3 of the next frame -> all outputs 0 on the next clk, no DataValid_o.
